// File: rtl/bexkat1_busarb_pkg.sv
// bexkat1_busarb_pkg
// Shared types for the bexkat1 two-master bus arbiter.
//   busarb_state_t  : arbiter FSM state; the encoding doubles as the grant
//                     trace value (00 idle, 01 instruction, 10 data).
//   busarb_master_t : identifies one of the two masters (fetch or data).
//   master_state()  : maps a master to the grant state that serves it.
//   other_master()  : the opposite master, used for round-robin choice.
package bexkat1_busarb_pkg;

    typedef enum logic [1:0] {
        BA_IDLE = 2'b00,
        BA_INS  = 2'b01,
        BA_DAT  = 2'b10
    } busarb_state_t;

    typedef enum logic {
        M_INS = 1'b0,
        M_DAT = 1'b1
    } busarb_master_t;

    function automatic busarb_state_t master_state(input busarb_master_t m);
        busarb_state_t s;
        case (m)
            M_INS:   s = BA_INS;
            M_DAT:   s = BA_DAT;
            default: s = BA_IDLE;
        endcase
        return s;
    endfunction

    function automatic busarb_master_t other_master(input busarb_master_t m);
        busarb_master_t o;
        case (m)
            M_INS:   o = M_DAT;
            M_DAT:   o = M_INS;
            default: o = M_INS;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/bexkat1_busarb.sv
// bexkat1_busarb
// Merges the bexkat1p core's instruction-fetch port and data port onto one
// shared slave bus. Arbitration is round-robin per transfer: whenever the
// slave acks and the other master is waiting, ownership passes to it at the
// next edge with no idle bubble. Bus drive and ack steering are
// combinational from the registered state plus the master inputs.
//
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   ins_cyc/we/adr/sel_i      : instruction master request (we is ignored)
//   ins_ack_o, ins_dat_o      : instruction master response
//   dat_cyc/we/adr/sel/dat_i  : data master request
//   dat_ack_o, dat_dat_o      : data master response
//   bus_cyc/we/adr/sel/dat_o  : shared slave bus request
//   bus_ack_i, bus_dat_i      : slave response
//   grant_o                   : current grant (00 idle, 01 ins, 10 dat)
module bexkat1_busarb
    import bexkat1_busarb_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ins_cyc_i,
    input  logic                  ins_we_i,
    input  logic [AWIDTH-1:0]     ins_adr_i,
    input  logic [DWIDTH/8-1:0]   ins_sel_i,
    output logic                  ins_ack_o,
    output logic [DWIDTH-1:0]     ins_dat_o,
    input  logic                  dat_cyc_i,
    input  logic                  dat_we_i,
    input  logic [AWIDTH-1:0]     dat_adr_i,
    input  logic [DWIDTH/8-1:0]   dat_sel_i,
    input  logic [DWIDTH-1:0]     dat_dat_i,
    output logic                  dat_ack_o,
    output logic [DWIDTH-1:0]     dat_dat_o,
    output logic                  bus_cyc_o,
    output logic                  bus_we_o,
    output logic [AWIDTH-1:0]     bus_adr_o,
    output logic [DWIDTH/8-1:0]   bus_sel_o,
    output logic [DWIDTH-1:0]     bus_dat_o,
    input  logic                  bus_ack_i,
    input  logic [DWIDTH-1:0]     bus_dat_i,
    output logic [1:0]            grant_o
);

    localparam int SWIDTH = DWIDTH / 8;

    busarb_state_t  state_q;
    busarb_state_t  state_d;
    busarb_master_t last_q;
    busarb_master_t last_d;

    // The fetch port never writes; its write enable is deliberately dropped.
    logic unused_ins_we_s;
    assign unused_ins_we_s = ins_we_i;

    // State and last-granted registers; reset abandons any transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BA_IDLE;
            last_q  <= M_INS;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state: idle pick, cyc-drop fallthrough and per-ack handoff.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            BA_IDLE: begin
                if (ins_cyc_i && dat_cyc_i) begin
                    // Contention from idle goes to whoever was not served last.
                    state_d = master_state(other_master(last_q));
                end else if (ins_cyc_i) begin
                    state_d = BA_INS;
                end else if (dat_cyc_i) begin
                    state_d = BA_DAT;
                end else begin
                    state_d = BA_IDLE;
                end
            end
            BA_INS: begin
                // A cyc drop takes priority over an ack in the same cycle.
                if (!ins_cyc_i) begin
                    state_d = dat_cyc_i ? BA_DAT : BA_IDLE;
                end else if (bus_ack_i && dat_cyc_i) begin
                    state_d = BA_DAT;
                end else begin
                    state_d = BA_INS;
                end
            end
            BA_DAT: begin
                if (!dat_cyc_i) begin
                    state_d = ins_cyc_i ? BA_INS : BA_IDLE;
                end else if (bus_ack_i && ins_cyc_i) begin
                    state_d = BA_INS;
                end else begin
                    state_d = BA_DAT;
                end
            end
            default: begin
                state_d = BA_IDLE;
            end
        endcase

        // Staying in a grant re-records the same master, so updating on any
        // non-idle next state equals updating on entry.
        case (state_d)
            BA_INS:  last_d = M_INS;
            BA_DAT:  last_d = M_DAT;
            default: last_d = last_q;
        endcase
    end

    // Output decode: bus mux, ack steering and grant trace.
    always_comb begin
        bus_cyc_o = 1'b0;
        bus_we_o  = 1'b0;
        bus_adr_o = {AWIDTH{1'b0}};
        bus_sel_o = {SWIDTH{1'b0}};
        bus_dat_o = {DWIDTH{1'b0}};
        ins_ack_o = 1'b0;
        dat_ack_o = 1'b0;
        case (state_q)
            BA_INS: begin
                bus_cyc_o = ins_cyc_i;
                bus_adr_o = ins_adr_i;
                bus_sel_o = ins_sel_i;
                ins_ack_o = bus_ack_i;
            end
            BA_DAT: begin
                bus_cyc_o = dat_cyc_i;
                bus_we_o  = dat_we_i;
                bus_adr_o = dat_adr_i;
                bus_sel_o = dat_sel_i;
                bus_dat_o = dat_dat_i;
                dat_ack_o = bus_ack_i;
            end
            default: begin
                // Idle: bus quiet, and a stray slave ack reaches nobody.
                bus_cyc_o = 1'b0;
            end
        endcase
        // Read data goes to both masters; each qualifies it with its own ack.
        ins_dat_o = bus_dat_i;
        dat_dat_o = bus_dat_i;
        grant_o   = state_q;
    end

endmodule
